benes_select_sequencer: RTL and testbench

- Control stage directly upstream of the Benes buffer interconnect; drives its per-stage switch selects: the module-direction plane and the slot-direction plane, each STAGE_NUM x SWITCH_NUM.
- Holds a small table of pre-loaded routing configurations.
- On an issue command, delivers one configuration with a stage-aligned skew, so each switch stage changes exactly when the matching data wavefront reaches it through the inter-stage buffers.
- Back-to-back issues stream with no bubbles.

---
 rtl/benes_select_sequencer_pkg.sv | 12 +
 rtl/benes_select_delay.sv | 28 ++
 rtl/benes_select_sequencer.sv | 77 +++++++
 tb/tb_benes_select_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/benes_select_sequencer_pkg.sv
// benes_select_sequencer_pkg: shared Benes sizing constants and per-stage select word type
package benes_select_sequencer_pkg;
  localparam int SIZE = 32;
  localparam int SWITCH_NUM = SIZE / 2;
  localparam int STAGE_NUM = 2 * $clog2(SIZE) - 1;
  localparam int CYCLES = 2;
  localparam int CFG_DEPTH = 8;
  typedef struct packed {
    logic [SWITCH_NUM-1:0] slot_sel;
    logic [SWITCH_NUM-1:0] module_sel;
  } BenesSelectCfg;
endpackage

// File: rtl/benes_select_delay.sv
// benes_select_delay: resettable fixed-depth shift register, depth 0 is a wire
module benes_select_delay #(
  parameter int W = 32,
  parameter int D = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_d
);
  if (D == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = ^{clk, rst};
    assign o_d = i_d;
  end else begin : g_line
    logic [W-1:0] line_q [D];
    logic [W-1:0] line_d [D];
    always_comb begin
      line_d[0] = i_d;
      for (int i = 1; i < D; i++) line_d[i] = line_q[i-1];
    end
    always_ff @(posedge clk) begin
      if (rst) line_q <= '{default: '0};
      else line_q <= line_d;
    end
    assign o_d = line_q[D-1];
  end
endmodule

// File: rtl/benes_select_sequencer.sv
// benes_select_sequencer: config table plus stage-skewed delivery of Benes switch selects
module benes_select_sequencer
  import benes_select_sequencer_pkg::*;
#(
  parameter int SWITCH_NUM  = benes_select_sequencer_pkg::SWITCH_NUM,
  parameter int STAGE_NUM   = benes_select_sequencer_pkg::STAGE_NUM,
  parameter int CFG_DEPTH   = benes_select_sequencer_pkg::CFG_DEPTH,
  parameter int STAGE_DELAY = benes_select_sequencer_pkg::CYCLES
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         i_cfg_wr_valid,
  input  logic [$clog2(CFG_DEPTH)-1:0]                 i_cfg_wr_idx,
  input  logic [$clog2(STAGE_NUM)-1:0]                 i_cfg_wr_stage,
  input  logic                                         i_cfg_wr_plane,
  input  logic [SWITCH_NUM-1:0]                        i_cfg_wr_data,
  input  logic                                         i_issue_valid,
  input  logic [$clog2(CFG_DEPTH)-1:0]                 i_issue_idx,
  output logic                                         o_issue_ready,
  output logic [SWITCH_NUM-1:0]                        o_module_select [0:STAGE_NUM-1],
  output logic [SWITCH_NUM-1:0]                        o_slot_select [0:STAGE_NUM-1],
  output logic                                         o_done,
  output logic [$clog2(CFG_DEPTH)-1:0]                 o_done_idx,
  output logic [$clog2(STAGE_NUM*STAGE_DELAY+1)-1:0]   o_inflight
);
  localparam int IW = $clog2(CFG_DEPTH);
  localparam int SW = $clog2(STAGE_NUM);
  localparam int FW = $clog2(STAGE_NUM * STAGE_DELAY + 1);
  localparam int W = 2 * SWITCH_NUM;
  logic [W-1:0] cfg_q [CFG_DEPTH][STAGE_NUM];
  logic [W-1:0] cfg_d [CFG_DEPTH][STAGE_NUM];
  logic [W-1:0] snap_q [STAGE_NUM];
  logic [W-1:0] snap_d [STAGE_NUM];
  logic [W-1:0] line [STAGE_NUM];
  logic [IW:0] tag_q, tag_d, tag_out;
  logic [FW-1:0] inflight_q, inflight_d;
  logic issue;
  assign o_issue_ready = ~rst;
  assign issue = i_issue_valid & o_issue_ready;
  // snapshots hold between issues, so each delay line tail keeps the last config it delivered
  always_comb begin
    cfg_d = cfg_q;
    if (i_cfg_wr_valid && {1'b0, i_cfg_wr_stage} < (SW+1)'(STAGE_NUM))
      cfg_d[i_cfg_wr_idx][i_cfg_wr_stage] = i_cfg_wr_plane
        ? {i_cfg_wr_data, cfg_q[i_cfg_wr_idx][i_cfg_wr_stage][SWITCH_NUM-1:0]}
        : {cfg_q[i_cfg_wr_idx][i_cfg_wr_stage][W-1:SWITCH_NUM], i_cfg_wr_data};
    for (int i = 0; i < STAGE_NUM; i++) snap_d[i] = issue ? cfg_q[i_issue_idx][i] : snap_q[i];
    tag_d = {issue, issue ? i_issue_idx : IW'(0)};
    inflight_d = inflight_q + FW'(issue) - FW'(tag_out[IW]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q <= '{default: '0};
      snap_q <= '{default: '0};
      tag_q <= '0;
      inflight_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      snap_q <= snap_d;
      tag_q <= tag_d;
      inflight_q <= inflight_d;
    end
  end
  for (genvar s = 0; s < STAGE_NUM; s++) begin : g_stage
    benes_select_delay #(.W(W), .D(STAGE_DELAY * s)) u_dly (
      .clk(clk), .rst(rst), .i_d(snap_q[s]), .o_d(line[s])
    );
    assign o_module_select[s] = line[s][SWITCH_NUM-1:0];
    assign o_slot_select[s] = line[s][W-1:SWITCH_NUM];
  end
  benes_select_delay #(.W(IW + 1), .D(STAGE_DELAY * (STAGE_NUM - 1))) u_tag (
    .clk(clk), .rst(rst), .i_d(tag_q), .o_d(tag_out)
  );
  assign o_done = tag_out[IW];
  assign o_done_idx = tag_out[IW-1:0];
  assign o_inflight = inflight_q;
endmodule

// File: tb/tb_benes_select_sequencer.sv
// tb_benes_select_sequencer: directed checks of reset, skew timing, streaming and snapshot semantics
module tb_benes_select_sequencer;
  logic clk, rst;
  logic wv, wpl, iv, rdy, done;
  logic [2:0] widx, iidx, didx;
  logic [3:0] wst;
  logic [15:0] wd;
  logic [15:0] msel [0:8];
  logic [15:0] ssel [0:8];
  logic [4:0] infl;
  int nchk, nerr;
  logic [15:0] pat [3];
  logic [15:0] e;
  benes_select_sequencer dut (
    .clk(clk), .rst(rst),
    .i_cfg_wr_valid(wv), .i_cfg_wr_idx(widx), .i_cfg_wr_stage(wst),
    .i_cfg_wr_plane(wpl), .i_cfg_wr_data(wd),
    .i_issue_valid(iv), .i_issue_idx(iidx), .o_issue_ready(rdy),
    .o_module_select(msel), .o_slot_select(ssel),
    .o_done(done), .o_done_idx(didx), .o_inflight(infl)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [2:0] idx, input logic [3:0] st, input logic pl, input logic [15:0] d);
    wv = 1'b1; widx = idx; wst = st; wpl = pl; wd = d;
    tick();
    wv = 1'b0;
  endtask
  function automatic logic any_sel();
    logic r;
    r = 1'b0;
    for (int s = 0; s < 9; s++) r = r | (|msel[s]) | (|ssel[s]);
    return r;
  endfunction
  initial begin
    nchk = 0; nerr = 0;
    pat[0] = 16'hAAAA; pat[1] = 16'h5555; pat[2] = 16'hFFFF;
    rst = 1'b1; wv = 1'b0; widx = '0; wst = '0; wpl = 1'b0; wd = '0; iv = 1'b0; iidx = '0;
    repeat (3) tick();
    chk("rst_ready", rdy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_idx", didx, 0);
    chk("rst_inflight", infl, 0);
    chk("rst_sel", any_sel(), 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", rdy, 1);
    // reset clears the table
    for (int i = 0; i < 9; i++) wr(3'd5, 4'(i), 1'(i), 16'($urandom) | 16'h0001);
    wr(3'd5, 4'd15, 1'b0, 16'hBEEF);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    iv = 1'b1; iidx = 3'd5;
    tick();
    iv = 1'b0;
    chk("a_inflight1", infl, 1);
    for (int c = 1; c < 17; c++) begin
      chk("a_no_done", done, 0);
      tick();
    end
    chk("a_done", done, 1);
    chk("a_done_idx", didx, 5);
    chk("a_sel_zero", any_sel(), 0);
    tick();
    chk("a_done_off", done, 0);
    chk("a_inflight0", infl, 0);
    // skew timing
    for (int s = 0; s < 9; s++) wr(3'd2, 4'(s), 1'b0, 16'h0001 << s);
    iv = 1'b1; iidx = 3'd2;
    tick();
    iv = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      for (int s = 0; s < 9; s++) begin
        e = (c >= 1 + 2 * s) ? (16'h0001 << s) : 16'h0000;
        chk($sformatf("b_mod_s%0d_c%0d", s, c), msel[s], e);
      end
      chk($sformatf("b_done_c%0d", c), done, (c == 17) ? 1 : 0);
      if (c == 17) chk("b_done_idx", didx, 2);
      if (c < 17) tick();
    end
    tick();
    // streaming
    for (int k = 0; k < 3; k++)
      for (int s = 0; s < 9; s++) wr(3'(k), 4'(s), 1'b0, pat[k]);
    for (int k = 0; k < 3; k++) begin
      iv = 1'b1; iidx = 3'(k);
      tick();
    end
    iv = 1'b0;
    for (int c = 3; c <= 20; c++) begin
      for (int s = 0; s < 9; s++) begin
        e = (c < 1 + 2 * s) ? (16'h0001 << s) : pat[(c - 1 - 2 * s > 2) ? 2 : c - 1 - 2 * s];
        chk($sformatf("c_mod_s%0d_c%0d", s, c), msel[s], e);
      end
      chk($sformatf("c_done_c%0d", c), done, (c >= 17 && c <= 19) ? 1 : 0);
      if (c >= 17 && c <= 19) chk($sformatf("c_done_idx_c%0d", c), didx, c - 17);
      chk($sformatf("c_inflight_c%0d", c), infl, ((c < 3) ? c : 3) - ((c <= 17) ? 0 : (c >= 20) ? 3 : c - 17));
      tick();
    end
    // read-before-write
    wr(3'd4, 4'd0, 1'b1, 16'h0F0F);
    wv = 1'b1; widx = 3'd4; wst = 4'd0; wpl = 1'b1; wd = 16'h1234;
    iv = 1'b1; iidx = 3'd4;
    tick();
    wv = 1'b0;
    chk("d_slot_old", ssel[0], 16'h0F0F);
    chk("d_mod0", msel[0], 16'h0000);
    tick();
    iv = 1'b0;
    chk("d_slot_new", ssel[0], 16'h1234);
    repeat (20) tick();
    chk("d_inflight0", infl, 0);
    // write after issue
    wr(3'd3, 4'd8, 1'b0, 16'h00F0);
    iv = 1'b1; iidx = 3'd3;
    tick();
    iv = 1'b0;
    for (int c = 1; c < 17; c++) begin
      if (c == 4) begin
        wv = 1'b1; widx = 3'd3; wst = 4'd8; wpl = 1'b0; wd = 16'hC3C3;
      end
      if (c == 16) chk("e_stage8_prev", msel[8], 16'h0000);
      tick();
      wv = 1'b0;
    end
    chk("e_stage8_old", msel[8], 16'h00F0);
    chk("e_done", done, 1);
    chk("e_done_idx", didx, 3);
    iv = 1'b1; iidx = 3'd3;
    tick();
    iv = 1'b0;
    repeat (16) tick();
    chk("e_stage8_new", msel[8], 16'hC3C3);
    chk("e_done2", done, 1);
    repeat (3) tick();
    // reset mid-flight
    iv = 1'b1; iidx = 3'd2;
    tick();
    iv = 1'b0;
    chk("f_stage0", msel[0], 16'hFFFF);
    repeat (5) tick();
    chk("f_inflight1", infl, 1);
    rst = 1'b1;
    tick();
    chk("f_sel_zero", any_sel(), 0);
    chk("f_inflight0", infl, 0);
    chk("f_ready0", rdy, 0);
    chk("f_done0", done, 0);
    rst = 1'b0;
    for (int c = 8; c <= 20; c++) begin
      tick();
      chk($sformatf("f_no_done_c%0d", c), done, 0);
    end
    chk("f_sel_zero_end", any_sel(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
